// File: rtl/mod_inverse.sv
// rtl/mod_inverse.sv - sequential modular inverter over the secp256k1 field (binary extended Euclid)
// One add/subtract/shift step per cycle; invariants x1*a == u and x2*a == v (mod P).

module mod_inverse #(
    parameter logic [255:0] P = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [255:0] a,
    output logic         Busy,
    output logic         Done,
    output logic         Error,
    output logic [255:0] inverse
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REDUCE,
        S_CHECK,
        S_HALVE_U,
        S_HALVE_V,
        S_SUBTRACT,
        S_FINISH
    } state_t;

    localparam logic [256:0] P_EXT = {1'b0, P};
    localparam logic [256:0] ONE   = 257'd1;

    state_t       state_q, state_d;
    logic [256:0] u_q, u_d;
    logic [256:0] v_q, v_d;
    logic [256:0] x1_q, x1_d;
    logic [256:0] x2_q, x2_d;

    // x/2 mod P for x < P: an odd x is made even by adding P, which fits in 257 bits.
    function automatic logic [256:0] halve_mod(input logic [256:0] x);
        logic [256:0] s;
        s = x + (x[0] ? P_EXT : 257'd0);
        return s >> 1;
    endfunction

    function automatic logic [256:0] sub_mod(input logic [256:0] x, input logic [256:0] y);
        if (x >= y) begin
            return x - y;
        end
        return (x + P_EXT) - y;
    endfunction

    always_comb begin
        state_d = state_q;
        u_d     = u_q;
        v_d     = v_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        case (state_q)
            S_IDLE, S_FINISH: begin
                if (Start) begin
                    u_d     = {1'b0, a};
                    v_d     = P_EXT;
                    x1_d    = ONE;
                    x2_d    = 257'd0;
                    state_d = S_REDUCE;
                end
            end
            S_REDUCE: begin
                // a < 2P, so one conditional subtraction fully reduces it.
                if (u_q >= P_EXT) begin
                    u_d = u_q - P_EXT;
                end
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (u_q == 257'd0 || u_q == ONE || v_q == ONE) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_HALVE_U;
                end
            end
            S_HALVE_U: begin
                if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = halve_mod(x1_q);
                end else begin
                    state_d = S_HALVE_V;
                end
            end
            S_HALVE_V: begin
                if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = halve_mod(x2_q);
                end else begin
                    state_d = S_SUBTRACT;
                end
            end
            S_SUBTRACT: begin
                if (u_q >= v_q) begin
                    u_d  = u_q - v_q;
                    x1_d = sub_mod(x1_q, x2_q);
                end else begin
                    v_d  = v_q - u_q;
                    x2_d = sub_mod(x2_q, x1_q);
                end
                state_d = S_CHECK;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            u_q     <= 257'd0;
            v_q     <= 257'd0;
            x1_q    <= 257'd0;
            x2_q    <= 257'd0;
        end else begin
            state_q <= state_d;
            u_q     <= u_d;
            v_q     <= v_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
        end
    end

    // u only reaches 0 in Finish when the operand was a multiple of P.
    always_comb begin
        Busy    = (state_q != S_IDLE);
        Done    = (state_q == S_FINISH);
        Error   = Done && (u_q == 257'd0);
        inverse = 256'd0;
        if (Done && !Error) begin
            inverse = (u_q == ONE) ? x1_q[255:0] : x2_q[255:0];
        end
    end

endmodule

// File: tb/tb_mod_inverse.sv
// tb/tb_mod_inverse.sv - randomized self-checking bench for mod_inverse
// Results are judged by a*inverse mod P == 1 using wide integer arithmetic.

module tb_mod_inverse;

    localparam logic [255:0] P    = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam logic [255:0] INV2 = 256'h7FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF7FFFFE18;
    localparam int LIMIT = 3072;
    localparam int NRAND = 25;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         Start = 1'b0;
    logic [255:0] a = 256'd0;
    logic         Busy;
    logic         Done;
    logic         Error;
    logic [255:0] inverse;

    int vectors = 0;
    int miscompares = 0;

    mod_inverse dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .a       (a),
        .Busy    (Busy),
        .Done    (Done),
        .Error   (Error),
        .inverse (inverse)
    );

    always #5 Clk = ~Clk;

    function automatic bit is_inverse(input logic [255:0] x, input logic [255:0] y);
        logic [511:0] prod;
        logic [511:0] modulus;
        prod    = {256'd0, x} * {256'd0, y};
        modulus = {256'd0, P};
        return (y < P) && ((prod % modulus) == 512'd1);
    endfunction

    function automatic logic [255:0] rand_field();
        logic [255:0] r;
        do begin
            for (int k = 0; k < 8; k++) begin
                r[32*k +: 32] = $urandom;
            end
        end while (r == 256'd0 || r >= P);
        return r;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic [255:0] val);
        Start = 1'b1;
        a     = val;
        step();
        Start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!Done && cyc < LIMIT) begin
            step();
            cyc++;
        end
    endtask

    task automatic expect_quiet(input string name);
        vectors++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Error !== 1'b0 || inverse !== 256'd0) begin
            miscompares++;
            $display("FAIL %s busy=%b done=%b error=%b inverse=%h, required all 0",
                     name, Busy, Done, Error, inverse);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            Start = 1'b1;
            a     = 256'd5;
            step();
            expect_quiet("reset_hold");
        end
        Start = 1'b0;
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            expect_quiet("idle_after_reset");
        end
    endtask

    task automatic test_one();
        int cyc;
        issue(256'd1);
        wait_done(cyc);
        vectors++;
        if (Done !== 1'b1 || cyc != 3) begin
            miscompares++;
            $display("FAIL one_latency done=%b cycle=%0d, required done=1 at cycle 3", Done, cyc);
        end
        vectors++;
        if (inverse !== 256'd1 || Error !== 1'b0) begin
            miscompares++;
            $display("FAIL one_result inverse=%h error=%b, required 1 error=0", inverse, Error);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            vectors++;
            if (Done !== 1'b1 || inverse !== 256'd1) begin
                miscompares++;
                $display("FAIL one_hold done=%b inverse=%h, required done=1 inverse=1", Done, inverse);
            end
        end
    endtask

    task automatic test_known();
        int cyc;
        issue(256'd2);
        wait_done(cyc);
        vectors++;
        if (Done !== 1'b1 || inverse !== INV2 || Error !== 1'b0) begin
            miscompares++;
            $display("FAIL inv_two done=%b inverse=%h, required %h", Done, inverse, INV2);
        end
        issue(P + 256'd1);
        wait_done(cyc);
        vectors++;
        if (Done !== 1'b1 || inverse !== 256'd1 || Error !== 1'b0) begin
            miscompares++;
            $display("FAIL inv_p_plus_1 done=%b inverse=%h, required 1", Done, inverse);
        end
    endtask

    task automatic test_zero();
        logic [255:0] vals [2];
        int cyc;
        vals[0] = 256'd0;
        vals[1] = P;
        for (int i = 0; i < 2; i++) begin
            issue(vals[i]);
            wait_done(cyc);
            vectors++;
            if (Done !== 1'b1 || cyc != 3 || Error !== 1'b1 || inverse !== 256'd0) begin
                miscompares++;
                $display("FAIL zero_error a=%h done=%b cycle=%0d error=%b inverse=%h, required done=1 cycle 3 error=1 inverse=0",
                         vals[i], Done, cyc, Error, inverse);
            end
        end
    endtask

    task automatic test_random_back_to_back();
        logic [255:0] val;
        int cyc;
        for (int i = 0; i < NRAND; i++) begin
            val = rand_field();
            issue(val);
            vectors++;
            if (Done !== 1'b0 || Busy !== 1'b1) begin
                miscompares++;
                $display("FAIL restart_drop done=%b busy=%b, required done=0 busy=1", Done, Busy);
            end
            wait_done(cyc);
            vectors++;
            if (Done !== 1'b1) begin
                miscompares++;
                $display("FAIL rand_timeout a=%h no done within %0d cycles", val, LIMIT);
            end else if (Error !== 1'b0 || !is_inverse(val, inverse)) begin
                miscompares++;
                $display("FAIL rand_inverse a=%h inverse=%h error=%b, required a*inverse mod P == 1",
                         val, inverse, Error);
            end
        end
    endtask

    task automatic test_robust();
        int cyc;
        issue(256'd3);
        for (int i = 0; i < 5; i++) step();
        vectors++;
        if (Busy !== 1'b1 || Done !== 1'b0) begin
            miscompares++;
            $display("FAIL robust_busy busy=%b done=%b, required busy=1 done=0", Busy, Done);
        end
        issue(256'd7);
        wait_done(cyc);
        vectors++;
        if (Done !== 1'b1 || !is_inverse(256'd3, inverse)) begin
            miscompares++;
            $display("FAIL ignored_start done=%b inverse=%h, required inverse of 3", Done, inverse);
        end

        issue({8{32'hDEADBEEF}});
        cyc = 1;
        while (cyc < 100) begin
            step();
            cyc++;
        end
        vectors++;
        if (Busy !== 1'b1 || Done !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_at_100 busy=%b done=%b, required busy=1 done=0", Busy, Done);
        end
        Reset = 1'b1;
        step();
        expect_quiet("mid_op_reset");
        Reset = 1'b0;
        step();
        expect_quiet("idle_after_mid_reset");
        issue(256'd2);
        wait_done(cyc);
        vectors++;
        if (Done !== 1'b1 || inverse !== INV2 || Error !== 1'b0) begin
            miscompares++;
            $display("FAIL after_reset_two done=%b inverse=%h, required %h", Done, inverse, INV2);
        end
    endtask

    initial begin
        test_reset();
        test_one();
        test_known();
        test_zero();
        test_random_back_to_back();
        test_robust();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
